// File: rtl/wiredng_cache_pkg.sv
// ---------------------------------------------------------------------------
// wiredng_cache_pkg
// Shared types for the cache bank scheduler:
//   cache_tag_t        line tag, physical address bits [47:14]
//   cache_index_t      set index, address bits [13:4]
//   bank_cmd_t         registered SRAM command fields (way enable and tag
//                      are carried beside it, since their widths are
//                      parameters of the scheduler)
//   bank_sched_state_e scheduler FSM states
// ---------------------------------------------------------------------------
package wiredng_cache_pkg;

  localparam int CACHE_PA_LENGTH    = 48;
  localparam int CACHE_WAY_COUNT    = 4;
  localparam int CACHE_STARVE_LIMIT = 8;

  localparam logic [7:0] FULL_BMASK = 8'hFF;

  typedef logic [CACHE_PA_LENGTH-1:14] cache_tag_t;
  typedef logic [13:4]                 cache_index_t;

  typedef struct packed {
    logic         en;
    logic         we;
    cache_index_t addr;
    logic         word;
    logic [63:0]  wdata;
    logic [7:0]   bmask;
    logic         tag_we;
  } bank_cmd_t;

  typedef enum logic [0:0] {
    IDLE,
    RF_BEAT1
  } bank_sched_state_e;

endpackage

// File: rtl/wiredng_bank_starve_ctr.sv
// ---------------------------------------------------------------------------
// wiredng_bank_starve_ctr
// Counts consecutive cycles a valid load is refused. Saturates at LIMIT and
// clears whenever the load is accepted or withdrawn. force_grant is high
// while the count sits at LIMIT.
// Ports:
//   clk, rst      bank clock, async active-high reset
//   ld_valid      load request present
//   ld_ready      load accepted this cycle
//   force_grant   load has waited LIMIT cycles and must go next
// ---------------------------------------------------------------------------
module wiredng_bank_starve_ctr #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_valid,
  input  logic ld_ready,
  output logic force_grant
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!ld_valid || ld_ready) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_grant = (cnt == LIM);

endmodule

// File: rtl/wiredng_cache_bank_sched.sv
// ---------------------------------------------------------------------------
// wiredng_cache_bank_sched
// Single-port scheduler for one cache bank's data/tag SRAM. Arbitrates load
// lookups, store-hit writes and two-beat refills, and issues one registered
// SRAM command per cycle (visible the cycle after acceptance).
//
// Optional build macro: WIREDNG_BANK_HAZARD_EN
//   When defined, a load is refused if its index matches a write on the SRAM
//   port this cycle or last cycle, or the refill index during a burst.
//
// Ports:
//   clk, rst                         bank clock, async active-high reset
//   ld_valid_i/ld_index_i/ld_ready_o load lookup request
//   st_*                             store hit write (index, word, way,
//                                    data, byte mask)
//   rf_*                             refill beat (index, way, tag, data)
//   sram_*                           registered SRAM command
//   busy_o                           refill burst in progress
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | arbitrate: forced load > refill > store > load
// RF_BEAT1 | refill beat 0 written; only refill beat 1 may be accepted
// ---------------------------------------------------------------------------
module wiredng_cache_bank_sched
  import wiredng_cache_pkg::*;
#(
  parameter int WAY_COUNT    = CACHE_WAY_COUNT,
  parameter int PA_LENGTH    = CACHE_PA_LENGTH,
  parameter int STARVE_LIMIT = CACHE_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  input  logic [13:4]           ld_index_i,
  output logic                  ld_ready_o,
  input  logic                  st_valid_i,
  input  logic [13:4]           st_index_i,
  input  logic                  st_word_i,
  input  logic [WAY_COUNT-1:0]  st_way_i,
  input  logic [63:0]           st_data_i,
  input  logic [7:0]            st_mask_i,
  output logic                  st_ready_o,
  input  logic                  rf_valid_i,
  input  logic [13:4]           rf_index_i,
  input  logic [WAY_COUNT-1:0]  rf_way_i,
  input  logic [PA_LENGTH-1:14] rf_tag_i,
  input  logic [63:0]           rf_data_i,
  output logic                  rf_ready_o,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [13:4]           sram_addr_o,
  output logic                  sram_word_o,
  output logic [WAY_COUNT-1:0]  sram_way_we_o,
  output logic [63:0]           sram_wdata_o,
  output logic [7:0]            sram_bmask_o,
  output logic                  sram_tag_we_o,
  output logic [PA_LENGTH-1:14] sram_tag_o,
  output logic                  busy_o
);

  bank_sched_state_e     state;
  bank_cmd_t             cmd_q;
  logic [WAY_COUNT-1:0]  way_q;
  logic [PA_LENGTH-1:14] tag_q;
  logic                  force_grant;
  logic                  force_ld;
  logic                  hazard;

  wiredng_bank_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid_i),
    .ld_ready   (ld_ready_o),
    .force_grant(force_grant)
  );

`ifdef WIREDNG_BANK_HAZARD_EN
  // Index of the write that was on the SRAM port one cycle ago.
  logic        wr_vld_q;
  logic [13:4] wr_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_vld_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      wr_vld_q <= sram_en_o & sram_we_o;
      wr_idx_q <= sram_addr_o;
    end
  end

  assign hazard = (sram_en_o && sram_we_o && (ld_index_i == sram_addr_o)) ||
                  (wr_vld_q && (ld_index_i == wr_idx_q)) ||
                  (busy_o && (ld_index_i == rf_index_i));
`else
  assign hazard = 1'b0;
`endif

  // A forced load blocks the other requesters even when a hazard holds it
  // back, so the SRAM drains and the hazard clears within two cycles.
  assign force_ld = force_grant && ld_valid_i && (state == IDLE);

  always_comb begin
    ld_ready_o = 1'b0;
    st_ready_o = 1'b0;
    rf_ready_o = 1'b0;
    if (!rst) begin
      if (state == RF_BEAT1) begin
        rf_ready_o = rf_valid_i;
      end else if (force_ld) begin
        ld_ready_o = !hazard;
      end else if (rf_valid_i) begin
        rf_ready_o = 1'b1;
      end else if (st_valid_i) begin
        st_ready_o = 1'b1;
      end else if (ld_valid_i) begin
        ld_ready_o = !hazard;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cmd_q <= '0;
      way_q <= '0;
      tag_q <= '0;
    end else begin
      cmd_q <= '0;
      way_q <= '0;
      tag_q <= '0;
      if (rf_ready_o) begin
        cmd_q.en     <= 1'b1;
        cmd_q.we     <= 1'b1;
        cmd_q.addr   <= rf_index_i;
        cmd_q.word   <= (state == RF_BEAT1);
        cmd_q.wdata  <= rf_data_i;
        cmd_q.bmask  <= FULL_BMASK;
        cmd_q.tag_we <= (state == RF_BEAT1);
        way_q        <= rf_way_i;
        if (state == RF_BEAT1) begin
          tag_q <= rf_tag_i;
          state <= IDLE;
        end else begin
          state <= RF_BEAT1;
        end
      end else if (st_ready_o) begin
        cmd_q.en    <= 1'b1;
        cmd_q.we    <= 1'b1;
        cmd_q.addr  <= st_index_i;
        cmd_q.word  <= st_word_i;
        cmd_q.wdata <= st_data_i;
        cmd_q.bmask <= st_mask_i;
        way_q       <= st_way_i;
      end else if (ld_ready_o) begin
        cmd_q.en   <= 1'b1;
        cmd_q.addr <= ld_index_i;
      end
    end
  end

  assign sram_en_o     = cmd_q.en;
  assign sram_we_o     = cmd_q.we;
  assign sram_addr_o   = cmd_q.addr;
  assign sram_word_o   = cmd_q.word;
  assign sram_wdata_o  = cmd_q.wdata;
  assign sram_bmask_o  = cmd_q.bmask;
  assign sram_tag_we_o = cmd_q.tag_we;
  assign sram_way_we_o = way_q;
  assign sram_tag_o    = tag_q;
  assign busy_o        = (state == RF_BEAT1);

endmodule

// File: tb/tb_wiredng_cache_bank_sched.sv
// Testbench for wiredng_cache_bank_sched: directed scenarios followed by
// randomized traffic, checked against a priority/queue reference model.
module tb_wiredng_cache_bank_sched;

  localparam int LIMIT = 8;
`ifdef WIREDNG_BANK_HAZARD_EN
  localparam int HAZ_WAIT = 2;
`else
  localparam int HAZ_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, st_valid, rf_valid, st_word;
  logic [9:0]  ld_index, st_index, rf_index;
  logic [3:0]  st_way, rf_way;
  logic [63:0] st_data, rf_data;
  logic [7:0]  st_mask;
  logic [33:0] rf_tag;
  logic        ld_ready, st_ready, rf_ready;
  logic        sram_en, sram_we, sram_word, sram_tag_we, busy;
  logic [9:0]  sram_addr;
  logic [3:0]  sram_way_we;
  logic [63:0] sram_wdata;
  logic [7:0]  sram_bmask;
  logic [33:0] sram_tag;

  always #5 clk = ~clk;

  wiredng_cache_bank_sched dut (
    .clk(clk), .rst(rst),
    .ld_valid_i(ld_valid), .ld_index_i(ld_index), .ld_ready_o(ld_ready),
    .st_valid_i(st_valid), .st_index_i(st_index), .st_word_i(st_word),
    .st_way_i(st_way), .st_data_i(st_data), .st_mask_i(st_mask),
    .st_ready_o(st_ready),
    .rf_valid_i(rf_valid), .rf_index_i(rf_index), .rf_way_i(rf_way),
    .rf_tag_i(rf_tag), .rf_data_i(rf_data), .rf_ready_o(rf_ready),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_word_o(sram_word), .sram_way_we_o(sram_way_we),
    .sram_wdata_o(sram_wdata), .sram_bmask_o(sram_bmask),
    .sram_tag_we_o(sram_tag_we), .sram_tag_o(sram_tag), .busy_o(busy)
  );

  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic        word;
    logic [3:0]  way;
    logic [63:0] wdata;
    logic [7:0]  bmask;
    logic        tag_we;
    logic [33:0] tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;

  // reference model state
  bit         m_burst;
  int         m_starve;
  bit         h0v, h1v;
  logic [9:0] h0, h1;
  bit         g_ld, g_st, g_rf;
  bit         d_ld, d_st, d_rf;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // scoreboard monitor: every issued command must match the oldest expected one
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (sram_en) begin
        if (q.size() == 0) chk("unexpected_cmd", 1, 0);
        else begin
          e = q.pop_front();
          chk("cmd", {sram_we, sram_addr, sram_word, sram_way_we, sram_wdata,
                      sram_bmask, sram_tag_we, sram_tag}, e);
        end
      end else begin
        chk("idle_zero", {sram_we, sram_addr, sram_word, sram_way_we, sram_wdata,
                          sram_bmask, sram_tag_we, sram_tag}, '0);
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return {ld_ready, st_ready, rf_ready, busy, sram_en, sram_we, sram_addr,
            sram_word, sram_way_we, sram_wdata, sram_bmask, sram_tag_we, sram_tag};
  endfunction

  // one clock cycle: inputs already driven; predict grant, compare, advance
  task automatic step();
    exp_t e;
    bit haz, forced;
    #1;
    d_ld = ld_ready; d_st = st_ready; d_rf = rf_ready;
    haz = 0;
`ifdef WIREDNG_BANK_HAZARD_EN
    haz = (h0v && ld_index == h0) || (h1v && ld_index == h1) ||
          (m_burst && ld_index == rf_index);
`endif
    forced = !m_burst && (m_starve == LIMIT) && ld_valid;
    g_ld = 0; g_st = 0; g_rf = 0;
    if (m_burst)       g_rf = rf_valid;
    else if (forced)   g_ld = !haz;
    else if (rf_valid) g_rf = 1;
    else if (st_valid) g_st = 1;
    else if (ld_valid) g_ld = !haz;
    chk("ready", {d_ld, d_st, d_rf}, {g_ld, g_st, g_rf});
    chk("busy", busy, m_burst);
    e = '0;
    if (g_rf) begin
      e.we = 1; e.addr = rf_index; e.word = m_burst; e.way = rf_way;
      e.wdata = rf_data; e.bmask = 8'hFF; e.tag_we = m_burst;
      e.tag = m_burst ? rf_tag : '0;
      q.push_back(e);
    end else if (g_st) begin
      e.we = 1; e.addr = st_index; e.word = st_word; e.way = st_way;
      e.wdata = st_data; e.bmask = st_mask;
      q.push_back(e);
    end else if (g_ld) begin
      e.addr = ld_index;
      q.push_back(e);
    end
    h1v = h0v; h1 = h0;
    h0v = g_rf || g_st;
    h0  = g_rf ? rf_index : st_index;
    if (!ld_valid || g_ld) m_starve = 0;
    else if (m_starve < LIMIT) m_starve = m_starve + 1;
    if (g_rf) m_burst = !m_burst;
    @(negedge clk);
  endtask

  // async reset may land anywhere in a cycle; released on a falling edge
  task automatic do_reset();
    mon_en = 0;
    rst = 1;
    #1;
    chk("reset_outputs", all_outs(), '0);
    @(negedge clk);
    rst = 0;
    m_burst = 0; m_starve = 0; h0v = 0; h1v = 0; h0 = '0; h1 = '0;
    q.delete();
    mon_en = 1;
  endtask

  task automatic clear_inputs();
    ld_valid = 0; st_valid = 0; rf_valid = 0;
  endtask

  int n_st, n_wait;
  bit rf_phase;

  initial begin
    rst = 1;
    ld_valid = 1; ld_index = 10'h3;
    st_valid = 1; st_index = 10'h5; st_word = 0; st_way = 4'b0010;
    st_data = 64'h1111; st_mask = 8'hF0;
    rf_valid = 1; rf_index = 10'h7; rf_way = 4'b1000; rf_tag = 34'h2AB;
    rf_data = 64'hAAAA_0000;
    #2;
    do_reset();

    // first grant after reset goes to the refill
    step();
    chk("first_grant_rf", {sram_en, sram_we, sram_word, sram_bmask, sram_tag_we},
        {1'b1, 1'b1, 1'b0, 8'hFF, 1'b0});
    rf_data = 64'hAAAA_1111;
    step();
    clear_inputs();
    step(); step();

    // lone load
    ld_valid = 1; ld_index = 10'h123;
    step();
    chk("load_cmd", {sram_en, sram_we, sram_addr, sram_way_we, sram_wdata},
        {1'b1, 1'b0, 10'h123, 4'b0000, 64'h0});
    clear_inputs();
    step();

    // refill with a two-cycle stall between beats; others held off
    rf_valid = 1; rf_index = 10'h040; rf_way = 4'b0100; rf_tag = 34'h1;
    rf_data = 64'hDEAD_BEEF_0000_0000;
    ld_valid = 1; ld_index = 10'h200; st_valid = 1; st_index = 10'h201;
    step();
    chk("rf_beat0", {sram_we, sram_addr, sram_word, sram_way_we, sram_tag_we},
        {1'b1, 10'h040, 1'b0, 4'b0100, 1'b0});
    rf_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rf_gap", {busy, ld_ready, st_ready, rf_ready}, 4'b1000);
      step();
    end
    rf_valid = 1; rf_data = 64'hDEAD_BEEF_1111_1111;
    step();
    chk("rf_beat1", {sram_we, sram_word, sram_tag_we, sram_tag, busy},
        {1'b1, 1'b1, 1'b1, 34'h1, 1'b0});
    clear_inputs();
    step(); step();

    // starvation: store and load held valid
    ld_valid = 1; ld_index = 10'h300;
    st_valid = 1; st_index = 10'h301; st_way = 4'b0001; st_mask = 8'hFF;
    n_st = 0;
    d_ld = 0;
    for (int i = 0; i < 20 && !d_ld; i++) begin
      st_data = {$urandom(), $urandom()};
      step();
      if (d_st) n_st++;
    end
    chk("starve_store_grants", n_st, LIMIT);
    chk("starve_load_granted", d_ld, 1);
    step();
    chk("starve_cleared", {d_ld, d_st}, 2'b01);
    clear_inputs();
    step(); step();

    // store with partial mask to word 1
    st_valid = 1; st_index = 10'h055; st_word = 1; st_way = 4'b0001;
    st_mask = 8'h0F; st_data = 64'h0123_4567_89AB_CDEF;
    step();
    chk("store_fields", {sram_bmask, sram_way_we, sram_word},
        {8'h0F, 4'b0001, 1'b1});
    clear_inputs();
    step(); step();

    // read-after-write on the same index
    st_valid = 1; st_index = 10'h2AA; st_word = 0; st_mask = 8'hFF;
    step();
    st_valid = 0;
    ld_valid = 1; ld_index = 10'h2AA;
    n_wait = 0;
    d_ld = 0;
    for (int i = 0; i < 10 && !d_ld; i++) begin
      step();
      if (!d_ld) n_wait++;
    end
    chk("hazard_wait", n_wait, HAZ_WAIT);
    clear_inputs();
    step(); step();

    // reset in the middle of a burst aborts it; refill restarts at beat 0
    rf_valid = 1; rf_index = 10'h111; rf_way = 4'b0010;
    step();
    #2;
    do_reset();
    chk("abort_busy", busy, 0);
    step();
    chk("restart_beat0", {sram_en, sram_word, sram_tag_we}, 3'b100);
    step();
    clear_inputs();
    step(); step();

    // randomized traffic
    rf_phase = 0;
    g_ld = 0; g_st = 0; g_rf = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!(ld_valid && !g_ld)) begin
        ld_valid = ($urandom_range(0, 99) < 40);
        ld_index = 10'(10'h100 + $urandom_range(0, 7));
      end
      if (!(st_valid && !g_st)) begin
        st_valid = ($urandom_range(0, 99) < 35);
        st_index = 10'(10'h100 + $urandom_range(0, 7));
        st_word  = 1'($urandom());
        st_way   = 4'($urandom());
        st_mask  = 8'($urandom());
        st_data  = {$urandom(), $urandom()};
      end
      if (!(rf_valid && !g_rf)) begin
        if (!rf_phase) begin
          rf_valid = ($urandom_range(0, 99) < 20);
          rf_index = 10'(10'h100 + $urandom_range(0, 7));
          rf_way   = 4'($urandom());
          rf_tag   = 34'({$urandom(), $urandom()});
        end else begin
          rf_valid = ($urandom_range(0, 99) < 60);
        end
        rf_data = {$urandom(), $urandom()};
      end
      step();
      if (g_rf) rf_phase = !rf_phase;
    end
    // finish any open burst, then drain
    ld_valid = 0; st_valid = 0;
    rf_valid = rf_phase;
    step();
    clear_inputs();
    step(); step(); step();
    chk("queue_drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
